// File: rtl/popcount_accum.sv
// Frame accumulator for per-word population counts: sums FRAME_WORDS words,
// then holds the frame sum and its threshold flag until downstream takes it.
module popcount_accum #(
  parameter int FRAME_WORDS = 16,
  parameter int THRESH      = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [5:0]  cnt_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [11:0] sum_out,
  output logic        above,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        err
);

  localparam logic [6:0]  LAST_CNT = 7'(FRAME_WORDS - 1);
  localparam logic [11:0] THRESH_V = 12'(THRESH);
  localparam logic [5:0]  MAX_WORD = 6'd32;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_r, state_s;
  logic [11:0] acc_r, acc_s;
  logic [6:0]  cnt_r, cnt_s;
  logic [11:0] sum_s;
  logic [11:0] total_s;
  logic [5:0]  word_s;
  logic        above_s;
  logic        out_valid_s;
  logic        err_s;

  // A 32-input counter can never legally report more than 32.
  function automatic logic [5:0] clamp_word(input logic [5:0] w);
    if (w > MAX_WORD) begin
      return MAX_WORD;
    end else begin
      return w;
    end
  endfunction

  assign in_ready = (state_r == ACCUM);

  // Next-state and next-output decode; clr overrides every transfer.
  always_comb begin
    word_s      = clamp_word(cnt_in);
    total_s     = acc_r + {6'd0, word_s};
    state_s     = state_r;
    acc_s       = acc_r;
    cnt_s       = cnt_r;
    sum_s       = sum_out;
    above_s     = above;
    out_valid_s = out_valid;
    err_s       = err;
    if (clr) begin
      state_s     = ACCUM;
      acc_s       = 12'd0;
      cnt_s       = 7'd0;
      out_valid_s = 1'b0;
    end else begin
      case (state_r)
        ACCUM: begin
          if (in_valid) begin
            if (cnt_in > MAX_WORD) begin
              err_s = 1'b1;
            end else begin
              err_s = err;
            end
            // Last word of the frame goes straight into the result register.
            if (cnt_r == LAST_CNT) begin
              sum_s       = total_s;
              above_s     = (total_s >= THRESH_V);
              out_valid_s = 1'b1;
              acc_s       = 12'd0;
              cnt_s       = 7'd0;
              state_s     = HOLD;
            end else begin
              acc_s = total_s;
              cnt_s = cnt_r + 7'd1;
            end
          end else begin
            state_s = ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_s = 1'b0;
            state_s     = ACCUM;
          end else begin
            state_s = HOLD;
          end
        end
        default: begin
          state_s     = ACCUM;
          out_valid_s = 1'b0;
        end
      endcase
    end
  end

  // State, accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ACCUM;
      acc_r     <= 12'd0;
      cnt_r     <= 7'd0;
      sum_out   <= 12'd0;
      above     <= 1'b0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state_r   <= state_s;
      acc_r     <= acc_s;
      cnt_r     <= cnt_s;
      sum_out   <= sum_s;
      above     <= above_s;
      out_valid <= out_valid_s;
      err       <= err_s;
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// Scoreboard bench for popcount_accum: three instances (default, 64-word, 1-word
// frames) driven with directed and random traffic against a frame-sum model.
module tb_popcount_accum;

  logic        clk;
  logic        rst_n;
  logic        clr_a       [3];
  logic [5:0]  cnt_in_a    [3];
  logic        in_valid_a  [3];
  logic        in_ready_a  [3];
  logic [11:0] sum_out_a   [3];
  logic        above_a     [3];
  logic        out_valid_a [3];
  logic        out_ready_a [3];
  logic        err_a       [3];

  int n_tests;
  int n_fail;
  int rdy_mode;

  // Model state: words and running sum of the open frame, pending results.
  int          frame_n    [3];
  int          frame_sum  [3];
  logic [12:0] exp_q      [3][$];
  logic        err_exp    [3];
  int          last_sum   [3];
  logic        last_above [3];
  logic        pend;
  logic [12:0] exp_e;
  int          word_v;

  popcount_accum u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr_a[0]), .cnt_in(cnt_in_a[0]),
    .in_valid(in_valid_a[0]), .in_ready(in_ready_a[0]), .sum_out(sum_out_a[0]),
    .above(above_a[0]), .out_valid(out_valid_a[0]), .out_ready(out_ready_a[0]),
    .err(err_a[0])
  );

  popcount_accum #(.FRAME_WORDS(64), .THRESH(2047)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_a[1]), .cnt_in(cnt_in_a[1]),
    .in_valid(in_valid_a[1]), .in_ready(in_ready_a[1]), .sum_out(sum_out_a[1]),
    .above(above_a[1]), .out_valid(out_valid_a[1]), .out_ready(out_ready_a[1]),
    .err(err_a[1])
  );

  popcount_accum #(.FRAME_WORDS(1), .THRESH(16)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr_a[2]), .cnt_in(cnt_in_a[2]),
    .in_valid(in_valid_a[2]), .in_ready(in_ready_a[2]), .sum_out(sum_out_a[2]),
    .above(above_a[2]), .out_valid(out_valid_a[2]), .out_ready(out_ready_a[2]),
    .err(err_a[2])
  );

  function automatic int fw_of(input int g);
    return (g == 0) ? 16 : ((g == 1) ? 64 : 1);
  endfunction

  function automatic int th_of(input int g);
    return (g == 0) ? 256 : ((g == 1) ? 2047 : 16);
  endfunction

  task automatic chk(input string name, input int g, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t got=%0d want=%0d", name, g, $time, got, want);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor + scoreboard: checks at every falling edge, then advances the model
  // with the inputs that the next rising edge will see.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        if (!rst_n) begin
          chk("rst_out_valid", g, out_valid_a[g], 0);
          chk("rst_sum_out", g, sum_out_a[g], 0);
          chk("rst_above", g, above_a[g], 0);
          chk("rst_err", g, err_a[g], 0);
          chk("rst_in_ready", g, in_ready_a[g], 1);
          frame_n[g]    = 0;
          frame_sum[g]  = 0;
          exp_q[g].delete();
          err_exp[g]    = 1'b0;
          last_sum[g]   = 0;
          last_above[g] = 1'b0;
        end else begin
          pend = (exp_q[g].size() != 0);
          chk("in_ready", g, in_ready_a[g], pend ? 0 : 1);
          chk("out_valid", g, out_valid_a[g], pend ? 1 : 0);
          chk("sum_out_held", g, sum_out_a[g], last_sum[g]);
          chk("above_held", g, above_a[g], last_above[g]);
          chk("err", g, err_a[g], err_exp[g]);
          if (clr_a[g]) begin
            frame_n[g]   = 0;
            frame_sum[g] = 0;
            exp_q[g].delete();
          end else if (pend) begin
            if (out_ready_a[g]) begin
              exp_e = exp_q[g].pop_front();
              chk("result_sum", g, sum_out_a[g], exp_e[11:0]);
              chk("result_above", g, above_a[g], exp_e[12]);
            end
          end else if (in_valid_a[g]) begin
            word_v = (cnt_in_a[g] > 6'd32) ? 32 : int'(cnt_in_a[g]);
            if (cnt_in_a[g] > 6'd32) err_exp[g] = 1'b1;
            frame_n[g]   = frame_n[g] + 1;
            frame_sum[g] = frame_sum[g] + word_v;
            if (frame_n[g] == fw_of(g)) begin
              last_sum[g]   = frame_sum[g];
              last_above[g] = (frame_sum[g] >= th_of(g));
              exp_q[g].push_back({last_above[g], 12'(frame_sum[g])});
              frame_n[g]    = 0;
              frame_sum[g]  = 0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      out_ready_a[g] = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      for (int g = 0; g < 3; g++) in_valid_a[g] = 1'b0;
    end
  endtask

  task automatic send(input int g, input int v);
    int n;
    n = 0;
    tick();
    for (int k = 0; k < 3; k++) in_valid_a[k] = 1'b0;
    in_valid_a[g] = 1'b1;
    cnt_in_a[g]   = 6'(v);
    while (!in_ready_a[g]) begin
      n++;
      if (n > 100) begin
        $display("FAIL send_timeout inst%0d in_ready stuck low", g);
        $fatal(1, "in_ready never returned");
      end
      tick();
    end
  endtask

  task automatic clr_pulse(input int g, input logic with_valid);
    tick();
    for (int k = 0; k < 3; k++) in_valid_a[k] = 1'b0;
    clr_a[g]      = 1'b1;
    in_valid_a[g] = with_valid;
    cnt_in_a[g]   = 6'd5;
    tick();
    clr_a[g]      = 1'b0;
    in_valid_a[g] = 1'b0;
  endtask

  task automatic reset_pulse();
    tick();
    for (int k = 0; k < 3; k++) in_valid_a[k] = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic int rnd_word();
    if ($urandom_range(0, 19) == 0) return int'($urandom_range(33, 40));
    return int'($urandom_range(0, 32));
  endfunction

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rdy_mode = 1;
    rst_n    = 1'b1;
    for (int g = 0; g < 3; g++) begin
      clr_a[g]       = 1'b0;
      cnt_in_a[g]    = 6'd0;
      in_valid_a[g]  = 1'b0;
      out_ready_a[g] = 1'b1;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Defaults: 16 x 20 = 320, above threshold, taken immediately.
    for (int i = 0; i < 16; i++) send(0, 20);
    idle(3);
    // 16 x 10 = 160 held while downstream stalls for several cycles.
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) send(0, 10);
    idle(6);
    rdy_mode = 1;
    idle(2);
    // Threshold boundary: exactly 256 and 255.
    for (int i = 0; i < 16; i++) send(0, 16);
    idle(2);
    for (int i = 0; i < 15; i++) send(0, 16);
    send(0, 15);
    idle(2);
    // Partial frame aborted by clr with a simultaneous word, then 16 x 1.
    for (int i = 0; i < 7; i++) send(0, int'($urandom_range(0, 32)));
    clr_pulse(0, 1'b1);
    for (int i = 0; i < 16; i++) send(0, 1);
    idle(2);
    // clr while a result is pending discards it.
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) send(0, 9);
    idle(2);
    clr_pulse(0, 1'b0);
    rdy_mode = 1;
    idle(2);
    // Out-of-range word clamps to 32 and sets err, which survives clr.
    send(0, 40);
    for (int i = 0; i < 15; i++) send(0, 0);
    idle(2);
    clr_pulse(0, 1'b0);
    idle(2);
    // 64 x 32 = 2048 without wrap; one result per word when FRAME_WORDS = 1.
    for (int i = 0; i < 64; i++) send(1, 32);
    idle(3);
    for (int i = 0; i < 12; i++) send(2, rnd_word());
    idle(2);
    // Reset mid-frame, then reset during HOLD; following frames sum cleanly.
    for (int i = 0; i < 5; i++) send(0, 3);
    reset_pulse();
    for (int i = 0; i < 16; i++) send(0, int'($urandom_range(0, 32)));
    idle(2);
    rdy_mode = 0;
    for (int i = 0; i < 16; i++) send(0, 7);
    idle(2);
    reset_pulse();
    rdy_mode = 1;
    for (int i = 0; i < 16; i++) send(0, 2);
    idle(3);
    // Random traffic with random downstream backpressure and idle gaps.
    rdy_mode = 2;
    repeat (400) begin
      send(int'($urandom_range(0, 2)), rnd_word());
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rdy_mode = 1;
    idle(5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/popcount_accum.md
POPCOUNT_ACCUM -- requirements
Module: popcount_accum

Interface
REQ-001 SHALL provide parameter FRAME_WORDS, default 16, giving the number of population-count words summed per frame (legal range 1..64).
REQ-002 SHALL provide parameter THRESH, default 256, giving the frame-sum threshold for the above flag (legal range 0..2047).
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL provide port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL provide port clr, input, 1 bit: synchronous frame abort/clear.
REQ-006 SHALL provide port cnt_in, input, 6 bits: popcount of one 32-bit word from the upstream 32-input counter (legal 0..32).
REQ-007 SHALL provide port in_valid, input, 1 bit: cnt_in is valid this cycle.
REQ-008 SHALL provide port in_ready, output, 1 bit: block accepts cnt_in this cycle.
REQ-009 SHALL provide port sum_out, output, 12 bits: completed frame sum.
REQ-010 SHALL provide port above, output, 1 bit: sum_out >= THRESH.
REQ-011 SHALL provide port out_valid, output, 1 bit: sum_out and above are valid.
REQ-012 SHALL provide port out_ready, input, 1 bit: downstream accepts the result.
REQ-013 SHALL provide port err, output, 1 bit: sticky flag, set when an out-of-range cnt_in is accepted.

Function
REQ-014 SHALL implement two states: ACCUM (collecting words) and HOLD (presenting a result).
REQ-015 SHALL drive in_ready = 1 in ACCUM and in_ready = 0 in HOLD.
REQ-016 SHALL define input transfer as in_valid & in_ready at a rising clk edge; on each transfer, add cnt_in to a 12-bit accumulator and increment a 7-bit word counter.
REQ-017 SHALL clamp any transferred cnt_in > 32 to 32 before adding, and set err in the same cycle.
REQ-018 SHALL keep err set until reset; clr SHALL NOT clear err.
REQ-019 SHALL, on the transfer that brings the word counter to FRAME_WORDS, in that same edge: load sum_out with accumulator + word, load above, assert out_valid, clear accumulator and counter, and enter HOLD.
REQ-020 SHALL therefore have a latency of one cycle: out_valid is high the cycle after the last word is accepted.
REQ-021 SHALL compute above from the same value loaded into sum_out, with no extra cycle.
REQ-022 SHALL hold sum_out, above and out_valid stable in HOLD until out_valid & out_ready.
REQ-023 SHALL, on out_valid & out_ready in HOLD, deassert out_valid and return to ACCUM; in_ready SHALL be 1 in the following cycle.
REQ-024 SHALL hold sum_out and above at their last values after out_valid deasserts.
REQ-025 SHALL leave accumulator and counter unchanged when in_valid = 0 in ACCUM; idle gaps are legal anywhere in a frame.
REQ-026 SHALL, when FRAME_WORDS = 1, enter HOLD after every accepted word.
REQ-027 SHALL never overflow the accumulator: the maximum sum, 64*32 = 2048, fits in 12 bits, so no wrap handling is needed.
REQ-028 SHALL, on clr = 1 at an edge: clear accumulator, counter and out_valid, enter ACCUM, and ignore any simultaneous input or output transfer.
REQ-029 SHALL give clr priority over every other event.
REQ-030 SHALL, on clr, leave sum_out, above and err unchanged.

Reset
REQ-031 SHALL, while rst_n = 0, asynchronously force: state ACCUM, accumulator 0, counter 0, sum_out 0, above 0, out_valid 0, err 0.
REQ-032 SHALL hold in_ready = 1 while in reset.
REQ-033 SHALL discard any partial frame or pending result when reset is asserted mid-operation.
REQ-034 SHALL release reset cleanly: the first transfer after rst_n rises counts as word 1 of a new frame.

Verification
REQ-035 SHALL cover: defaults, 16 words of cnt_in = 20 with out_ready = 1 -> out_valid one cycle after word 16, sum_out = 320, above = 1.
REQ-036 SHALL cover: 16 words of cnt_in = 10 with out_ready = 0 for 5 cycles -> sum_out = 160, above = 0, held stable, in_ready = 0 throughout HOLD.
REQ-037 SHALL cover: one word with cnt_in = 40 -> that word counts as 32 and err = 1; err still 1 after a clr.
REQ-038 SHALL cover: 7 words, then clr together with in_valid, then 16 words of 1 -> sum_out = 16.
REQ-039 SHALL cover: FRAME_WORDS = 64 with 64 words of cnt_in = 32 -> sum_out = 2048 with no wrap; FRAME_WORDS = 1 -> one result per word.
REQ-040 SHALL cover: rst_n pulsed low mid-frame and during HOLD -> all outputs 0 immediately (asynchronously), and the next frame sums correctly.
